// File: rtl/axis_seq_latency_checker.sv
// Receive-side AXI-Stream checker: pseudo-random backpressure, per-source
// sequence/format/routing checks, good-packet counters and latency statistics.
//
// state  | meaning
// S_HEAD | waiting for beat 0 of a packet
// S_BODY | receiving beats 1..PKT_BEATS-1
// S_FAIL | error latched; beats drained, nothing checked or counted
module axis_seq_latency_checker #(
   parameter int          TDATA_WIDTH = 32,
   parameter int          TDEST_WIDTH = 2,
   parameter int          TID_WIDTH   = 2,
   parameter int          TDEST       = 0,
   parameter int          PKT_BEATS   = 2,
   parameter int          COUNT_WIDTH = 16,
   parameter int          LAT_WIDTH   = 32,
   parameter logic [15:0] READY_SEED  = 16'hACE1,
   localparam int         H           = TDATA_WIDTH / 2,
   localparam int         NSRC        = 2 ** TID_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic [15:0]                         ready_load,
   input  logic [H-1:0]                        ticks,
   input  logic                                axis_in_tvalid,
   output logic                                axis_in_tready,
   input  logic [TDATA_WIDTH-1:0]              axis_in_tdata,
   input  logic                                axis_in_tlast,
   input  logic [TID_WIDTH-1:0]                axis_in_tid,
   input  logic [TDEST_WIDTH-1:0]              axis_in_tdest,
   output logic [NSRC-1:0][COUNT_WIDTH-1:0]    recv_packets,
   output logic [LAT_WIDTH-1:0]                lat_sum,
   output logic [H-1:0]                        lat_max,
   output logic                                error,
   output logic [2:0]                          error_code
);

   typedef enum logic [1:0] {S_HEAD, S_BODY, S_FAIL} state_t;

   localparam logic [H-1:0]           LAST_IDX = H'(PKT_BEATS - 1);
   localparam logic [TDEST_WIDTH-1:0] MY_DEST  = TDEST_WIDTH'(TDEST);

   state_t                      state, state_nxt;
   logic [15:0]                 lfsr;
   logic                        ready_q;
   logic                        accept;
   logic [H-1:0]                hi, lo, hdr_lat, exp_eff;
   logic [NSRC-1:0][H-1:0]      exp_seq;
   logic [TID_WIDTH-1:0]        cap_tid;
   logic [H-1:0]                cap_seq, cap_lat, beat_cnt;
   logic                        done_q;
   logic [TID_WIDTH-1:0]        done_tid;
   logic [H-1:0]                done_lat;
   logic [2:0]                  code;
   logic                        start, complete;
   logic [LAT_WIDTH:0]          sum_ext;

   assign axis_in_tready = ready_q;
   assign accept  = axis_in_tvalid && ready_q;
   assign hi      = axis_in_tdata[TDATA_WIDTH-1:H];
   assign lo      = axis_in_tdata[H-1:0];
   assign hdr_lat = ticks - hi;
   assign sum_ext = {1'b0, lat_sum} + {{(LAT_WIDTH + 1 - H){1'b0}}, done_lat};

   // A back-to-back header from the same source sees the completion still pending.
   assign exp_eff = (done_q && done_tid == axis_in_tid) ? exp_seq[axis_in_tid] + H'(1)
                                                        : exp_seq[axis_in_tid];

   always_comb begin
      code      = 3'd0;
      state_nxt = state;
      start     = 1'b0;
      complete  = 1'b0;
      case (state)
         S_HEAD: if (accept) begin
            if (axis_in_tdest != MY_DEST)                code = 3'd1;
            else if (lo != exp_eff)                      code = 3'd2;
            else if (axis_in_tlast && PKT_BEATS > 1)     code = 3'd4;
            else if (!axis_in_tlast && PKT_BEATS == 1)   code = 3'd5;
            if (code != 3'd0) begin
               state_nxt = S_FAIL;
            end else begin
               start = 1'b1;
               if (PKT_BEATS == 1) complete = 1'b1;
               else                state_nxt = S_BODY;
            end
         end
         S_BODY: if (accept) begin
            if (axis_in_tdest != MY_DEST)                          code = 3'd1;
            else if (axis_in_tid != cap_tid)                       code = 3'd3;
            else if (axis_in_tlast && beat_cnt != LAST_IDX)        code = 3'd4;
            else if (!axis_in_tlast && beat_cnt == LAST_IDX)       code = 3'd5;
            else if (hi != beat_cnt || lo != cap_seq)              code = 3'd6;
            if (code != 3'd0) begin
               state_nxt = S_FAIL;
            end else if (beat_cnt == LAST_IDX) begin
               complete  = 1'b1;
               state_nxt = S_HEAD;
            end
         end
         default: state_nxt = S_FAIL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_HEAD;
         lfsr         <= READY_SEED;
         ready_q      <= 1'b0;
         exp_seq      <= '0;
         cap_tid      <= '0;
         cap_seq      <= '0;
         cap_lat      <= '0;
         beat_cnt     <= '0;
         done_q       <= 1'b0;
         done_tid     <= '0;
         done_lat     <= '0;
         recv_packets <= '0;
         lat_sum      <= '0;
         lat_max      <= '0;
         error        <= 1'b0;
         error_code   <= 3'd0;
      end else begin
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         ready_q <= enable && (lfsr <= ready_load);
         state   <= state_nxt;

         if (start) begin
            cap_tid  <= axis_in_tid;
            cap_seq  <= lo;
            cap_lat  <= hdr_lat;
            beat_cnt <= H'(1);
         end else if (accept && state == S_BODY) begin
            beat_cnt <= beat_cnt + H'(1);
         end

         if (code != 3'd0) begin
            error      <= 1'b1;
            error_code <= code;
         end

         // Statistics land one cycle after the last beat.
         done_q   <= complete;
         done_tid <= (state == S_HEAD) ? axis_in_tid : cap_tid;
         done_lat <= (state == S_HEAD) ? hdr_lat : cap_lat;

         if (done_q) begin
            exp_seq[done_tid] <= exp_seq[done_tid] + H'(1);
            if (recv_packets[done_tid] != '1)
               recv_packets[done_tid] <= recv_packets[done_tid] + COUNT_WIDTH'(1);
            lat_sum <= sum_ext[LAT_WIDTH] ? '1 : sum_ext[LAT_WIDTH-1:0];
            if (done_lat > lat_max) lat_max <= done_lat;
         end
      end
   end

endmodule

// File: tb/tb_axis_seq_latency_checker.sv
// Directed bench for axis_seq_latency_checker with default parameters
// (32-bit beats, 2-beat packets, endpoint 0).
module tb_axis_seq_latency_checker;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [15:0]       ready_load;
   logic [15:0]       ticks;
   logic              axis_in_tvalid;
   logic              axis_in_tready;
   logic [31:0]       axis_in_tdata;
   logic              axis_in_tlast;
   logic [1:0]        axis_in_tid;
   logic [1:0]        axis_in_tdest;
   logic [3:0][15:0]  recv_packets;
   logic [31:0]       lat_sum;
   logic [15:0]       lat_max;
   logic              error;
   logic [2:0]        error_code;

   int n_chk  = 0;
   int n_fail = 0;

   axis_seq_latency_checker dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .ready_load     (ready_load),
      .ticks          (ticks),
      .axis_in_tvalid (axis_in_tvalid),
      .axis_in_tready (axis_in_tready),
      .axis_in_tdata  (axis_in_tdata),
      .axis_in_tlast  (axis_in_tlast),
      .axis_in_tid    (axis_in_tid),
      .axis_in_tdest  (axis_in_tdest),
      .recv_packets   (recv_packets),
      .lat_sum        (lat_sum),
      .lat_max        (lat_max),
      .error          (error),
      .error_code     (error_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      axis_in_tvalid = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   // Present one beat and hold it until accepted; tready is registered so its
   // value at the negedge is the value seen by the next rising edge.
   task automatic send_beat(input logic [1:0] tid, input logic [1:0] dest,
                            input logic [31:0] data, input logic last);
      bit done = 0;
      int n    = 0;
      axis_in_tvalid = 1'b1;
      axis_in_tid    = tid;
      axis_in_tdest  = dest;
      axis_in_tdata  = data;
      axis_in_tlast  = last;
      while (!done && n < 2000) begin
         @(negedge clk);
         if (axis_in_tready) done = 1;
         @(posedge clk);
         #1;
         n++;
      end
      axis_in_tvalid = 1'b0;
      check("beat_accepted", 64'(done), 64'd1);
   endtask

   task automatic send_pkt(input logic [1:0] tid, input logic [15:0] seq, input logic [15:0] ts);
      send_beat(tid, 2'd0, {ts, seq}, 1'b0);
      send_beat(tid, 2'd0, {16'd1, seq}, 1'b1);
   endtask

   initial begin
      int cnt;
      rst_n          = 1'b0;
      enable         = 1'b1;
      ready_load     = 16'hFFFF;
      ticks          = 16'd100;
      axis_in_tvalid = 1'b0;
      axis_in_tdata  = '0;
      axis_in_tlast  = 1'b0;
      axis_in_tid    = '0;
      axis_in_tdest  = '0;

      // Reset state
      tick(1);
      check("rst_tready", 64'(axis_in_tready), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_code", 64'(error_code), 64'd0);
      check("rst_lat_sum", 64'(lat_sum), 64'd0);
      do_reset();
      check("tready_always", 64'(axis_in_tready), 64'd1);

      // 1: three good back-to-back packets from source 1, latency 5 each
      send_pkt(2'd1, 16'd0, 16'd95);
      send_pkt(2'd1, 16'd1, 16'd95);
      send_pkt(2'd1, 16'd2, 16'd95);
      check("t1_tready_held", 64'(axis_in_tready), 64'd1);
      tick(1);
      check("t1_recv1", 64'(recv_packets[1]), 64'd3);
      check("t1_recv0", 64'(recv_packets[0]), 64'd0);
      check("t1_lat_sum", 64'(lat_sum), 64'd15);
      check("t1_lat_max", 64'(lat_max), 64'd5);
      check("t1_error", 64'(error), 64'd0);

      // 2: source 2 skips seq 1
      send_pkt(2'd2, 16'd0, 16'd95);
      tick(1);
      check("t2_no_err_yet", 64'(error), 64'd0);
      send_beat(2'd2, 2'd0, {16'd95, 16'd2}, 1'b0);
      check("t2_error", 64'(error), 64'd1);
      check("t2_code", 64'(error_code), 64'd2);
      send_beat(2'd2, 2'd0, {16'd1, 16'd2}, 1'b1);
      send_pkt(2'd2, 16'd1, 16'd95);
      tick(1);
      check("t2_recv2", 64'(recv_packets[2]), 64'd1);
      check("t2_code_held", 64'(error_code), 64'd2);

      // 3: early tlast, missing tlast, wrong dest, tid switch, bad payload
      do_reset();
      send_beat(2'd0, 2'd0, {16'd95, 16'd0}, 1'b1);
      check("t3_early_last", 64'(error_code), 64'd4);
      do_reset();
      send_beat(2'd0, 2'd0, {16'd95, 16'd0}, 1'b0);
      send_beat(2'd0, 2'd0, {16'd1, 16'd0}, 1'b0);
      check("t3_no_last", 64'(error_code), 64'd5);
      do_reset();
      send_beat(2'd0, 2'd1, {16'd95, 16'd7}, 1'b0);
      check("t3_dest_prio", 64'(error_code), 64'd1);
      do_reset();
      send_beat(2'd0, 2'd0, {16'd95, 16'd0}, 1'b0);
      send_beat(2'd3, 2'd0, {16'd1, 16'd0}, 1'b1);
      check("t3_tid_switch", 64'(error_code), 64'd3);
      do_reset();
      send_beat(2'd0, 2'd0, {16'd95, 16'd0}, 1'b0);
      send_beat(2'd0, 2'd0, {16'd2, 16'd0}, 1'b1);
      check("t3_payload", 64'(error_code), 64'd6);

      // 4: ticks wrap, then a larger latency
      do_reset();
      ticks = 16'h0003;
      send_pkt(2'd0, 16'd0, 16'hFFFE);
      tick(1);
      check("t4_wrap_sum", 64'(lat_sum), 64'd5);
      check("t4_wrap_max", 64'(lat_max), 64'd5);
      ticks = 16'd20;
      send_pkt(2'd0, 16'd1, 16'd11);
      tick(1);
      check("t4_sum2", 64'(lat_sum), 64'd14);
      check("t4_max2", 64'(lat_max), 64'd9);
      check("t4_recv0", 64'(recv_packets[0]), 64'd2);
      enable = 1'b0;
      tick(2);
      check("t4_enable_off", 64'(axis_in_tready), 64'd0);
      enable = 1'b1;

      // 5: backpressure extremes
      do_reset();
      ready_load = 16'h0000;
      tick(2);
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (axis_in_tready) cnt++;
      end
      check("t5_never_ready", 64'(cnt), 64'd0);
      ready_load = 16'h8000;
      tick(2);
      cnt = 0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (axis_in_tready) cnt++;
      end
      check("t5_duty_50", 64'(cnt >= 1843 && cnt <= 2253), 64'd1);
      tick(1);
      ticks = 16'd100;
      send_pkt(2'd3, 16'd0, 16'd97);
      send_pkt(2'd3, 16'd1, 16'd97);
      send_pkt(2'd3, 16'd2, 16'd97);
      tick(1);
      check("t5_recv3", 64'(recv_packets[3]), 64'd3);
      check("t5_lat_sum", 64'(lat_sum), 64'd9);
      check("t5_error", 64'(error), 64'd0);
      ready_load = 16'hFFFF;

      // 6: reset mid-packet discards it
      do_reset();
      send_pkt(2'd1, 16'd0, 16'd95);
      send_beat(2'd1, 2'd0, {16'd95, 16'd1}, 1'b0);
      rst_n = 1'b0;
      tick(2);
      check("t6_rst_recv1", 64'(recv_packets[1]), 64'd0);
      check("t6_rst_lat_sum", 64'(lat_sum), 64'd0);
      check("t6_rst_tready", 64'(axis_in_tready), 64'd0);
      rst_n = 1'b1;
      tick(2);
      send_pkt(2'd1, 16'd0, 16'd95);
      tick(1);
      check("t6_recv1", 64'(recv_packets[1]), 64'd1);
      check("t6_error", 64'(error), 64'd0);
      check("t6_lat_max", 64'(lat_max), 64'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_seq_latency_checker.md
Name: axis_seq_latency_checker

Overview:
- Per-endpoint receive-side checker that consumes one AXI-Stream output port of the mesh.
- Applies pseudo-random backpressure.
- Checks packet integrity and routing:
  - destination matches this endpoint
  - per-source sequence numbers are in order
  - packet length is correct
  - payload format is correct
- Counts good packets per source and accumulates end-to-end latency from timestamps embedded by the upstream traffic generator.

Parameters:
- TDATA_WIDTH, 32, beat width; must be even. H = TDATA_WIDTH/2.
- TDEST_WIDTH, 2, destination field width.
- TID_WIDTH, 2, source-id width. NSRC = 2**TID_WIDTH.
- TDEST, 0, this endpoint's address.
- PKT_BEATS, 2, fixed beats per packet; range 1..2**H.
- COUNT_WIDTH, 16, per-source packet counter width.
- LAT_WIDTH, 32, latency accumulator width; must be >= H.
- READY_SEED, 16'hACE1, LFSR seed; must be nonzero.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset (synchronous, active-low).
- enable, input, 1, allows tready to assert.
- ready_load, input, 16, backpressure threshold: 0 = never ready, 16'hFFFF = always ready.
- ticks, input, H, free-running global timestamp.
- axis_in_tvalid, input, 1, beat valid.
- axis_in_tready, output, 1, beat ready (registered).
- axis_in_tdata, input, TDATA_WIDTH, beat data.
- axis_in_tlast, input, 1, last beat of packet.
- axis_in_tid, input, TID_WIDTH, source id.
- axis_in_tdest, input, TDEST_WIDTH, destination.
- recv_packets, output, [NSRC] x COUNT_WIDTH, good packets received per source.
- lat_sum, output, LAT_WIDTH, sum of latencies of good packets.
- lat_max, output, H, maximum latency of good packets.
- error, output, 1, sticky error flag.
- error_code, output, 3, first error cause.

Behaviour:
- **Reset.** Synchronous on clk, active-low. All outputs go to 0: tready, counters, lat_sum, lat_max, error, error_code. LFSR loads READY_SEED. Expected sequence numbers go to 0. FSM enters HEAD.
- **Beat format.**
  - Beat 0: tdata[TDATA_WIDTH-1:H] = send timestamp, tdata[H-1:0] = sequence number.
  - Beat k>0: upper half must equal k, lower half must equal the beat-0 sequence number.
- **Backpressure.**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle after reset.
  - tready register <= enable && (lfsr <= ready_load).
  - A beat is accepted only when tvalid && tready.
- **FSM.**
  - HEAD: waits for an accepted beat 0. Captures tid, seq and ts. Computes lat = (ticks - ts) mod 2**H. Sets beat count = 1. If tlast and PKT_BEATS==1, completes; else goes to BODY.
  - BODY: each accepted beat is checked, then beat count increments. The beat with count == PKT_BEATS-1 must carry tlast; the packet completes and the FSM returns to HEAD.
  - FAIL: entered on the first error. Beats are still accepted per LFSR, so the mesh never deadlocks. No further checks or counting. Left only by reset.
- **Checks.** Evaluated on every accepted beat; first error wins and error_code is latched.
  - 1: tdest != TDEST.
  - 2: beat-0 seq != expected[tid].
  - 3: tid differs from captured tid inside a packet.
  - 4: tlast before beat PKT_BEATS-1.
  - 5: no tlast on beat PKT_BEATS-1.
  - 6: body payload mismatch.
  - If multiple checks fail on the same beat, the lowest code is latched.
- **Completion of a good packet.** Takes effect in the cycle after the last beat is accepted:
  - expected[tid] increments mod 2**H.
  - recv_packets[tid] increments, saturating at all-ones.
  - lat_sum += lat, saturating at all-ones.
  - lat_max = max(lat_max, lat).
- **Error outputs.** error and error_code assert one cycle after the offending beat and hold until reset.
- **Boundary cases.**
  - ticks wrap is handled by the modular subtraction.
  - enable deasserted mid-packet: FSM state is held.
  - Reset mid-packet: the partial packet is discarded.
  - The beat after the last beat may be accepted back-to-back; there is no bubble.

Test Plan:
1. ready_load=16'hFFFF, enable=1, PKT_BEATS=2. Source 1 sends 3 packets with seq 0,1,2, ts=ticks-5, tdest=TDEST → recv_packets[1]=3, lat_sum=15, lat_max=5, error=0, tready held 1.
2. Source 2 sends seq 0 then seq 2 → error=1 and error_code=2 one cycle after the second header; recv_packets[2]=1. Further beats are still accepted.
3. Packet with tlast on beat 0 while PKT_BEATS=2 → error_code=4. Separately, no tlast on beat 1 → error_code=5.
4. Header ts=16'hFFFE while ticks=16'h0003 → lat=5, lat_max=5.
5. ready_load=0 → tready never asserts for 1000 cycles. ready_load=16'h8000 → tready duty cycle about 50% (±5%) over 4096 cycles, and all packets are still received correctly.
6. Assert rst_n=0 mid-packet after beat 0 → all counters 0 and FSM in HEAD. A new packet with seq 0 is accepted with no error.
